// File: rtl/addsub_pkg.sv
// Shared types for the bit-serial (chunked) add/subtract/compare unit.
// Holds the operation encoding, the control-state encoding and one small
// helper used by the control path.
package addsub_pkg;

  typedef enum logic [2:0] {
    ADD = 3'd0,
    SUB = 3'd1,
    EQ  = 3'd2,
    NE  = 3'd3,
    LT  = 3'd4,
    GE  = 3'd5,
    LTU = 3'd6,
    GEU = 3'd7
  } adderOp_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } addsub_state_t;

  // True for the equality-class compares that only need the zero flag.
  function automatic logic is_eq_op(adderOp_t o);
    return (o == EQ) || (o == NE);
  endfunction

endpackage

// File: rtl/addsub_chunk.sv
// One WADD-bit slice of the adder: sum, carry out, and the carry that
// entered the slice MSB (needed for signed overflow on the top slice).
module addsub_chunk #(
  parameter int WADD = 8
) (
  input  logic [WADD-1:0] a,
  input  logic [WADD-1:0] b,
  input  logic            cin,
  output logic [WADD-1:0] sum,
  output logic            cout,
  output logic            c_msb
);

  // Plain ripple add; carry into the MSB recovered from the MSB sum bit.
  always_comb begin
    {cout, sum} = {1'b0, a} + {1'b0, b} + {{WADD{1'b0}}, cin};
    c_msb       = a[WADD-1] ^ b[WADD-1] ^ sum[WADD-1];
  end

endmodule

// File: rtl/addsub_pipe.sv
// Multi-cycle add/subtract/compare unit. Operands are processed WADD bits
// per cycle, LSB chunk first, through a single addsub_chunk slice.
// Handshake: a request is taken on a rising edge where in_valid && in_ready;
// a result is handed over on a rising edge where out_valid && out_ready, and
// out/cond/ovf stay frozen while out_valid is high and out_ready is low.
// Build option: define ADDSUB_EQ_EARLY_EXIT_EN to let EQ/NE finish on the
// first nonzero difference chunk instead of always taking WIDTH/WADD cycles.
module addsub_pipe
  import addsub_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int WADD  = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  adderOp_t      op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [WIDTH-1:0] out,
  output logic          cond,
  output logic          ovf,
  output addsub_state_t state_dbg
);

  localparam int WADD_SAFE = (WADD < 1) ? 1 : WADD;
  localparam int NCYC      = WIDTH / WADD_SAFE;
  localparam int CNT_W     = (NCYC > 1) ? $clog2(NCYC) : 1;

  generate
    if ((WADD < 1) || ((WIDTH % WADD_SAFE) != 0)) begin : g_bad_cfg
      $error("addsub_pipe: WIDTH must be a positive multiple of WADD >= 1");
    end
  endgenerate

  addsub_state_t    state, state_nxt;
  adderOp_t         op_q;
  logic [WIDTH-1:0] a_sh, b_sh, res_q, out_q, full_sum;
  logic [CNT_W-1:0] cnt;
  logic             carry, nz, cond_q, ovf_q;
  logic             accept, is_sub, last_chunk, early_hit, finish;
  logic             nz_next, v_flag, lt_flag, ltu_flag, cond_nxt, ovf_nxt;
  logic [WADD-1:0]  a_k, b_k, sum_k;
  logic             cout_k, cmsb_k;

  // Operand slice for the current chunk; B is inverted for every non-ADD op.
  always_comb begin
    is_sub = (op_q != ADD);
    a_k    = a_sh[WADD-1:0];
    b_k    = b_sh[WADD-1:0] ^ {WADD{is_sub}};
  end

  addsub_chunk #(.WADD(WADD)) u_chunk (
    .a     (a_k),
    .b     (b_k),
    .cin   (carry),
    .sum   (sum_k),
    .cout  (cout_k),
    .c_msb (cmsb_k)
  );

  // Completion detection and flag evaluation from the chunk just computed.
  always_comb begin
    nz_next    = nz | (|sum_k);
    last_chunk = (cnt == CNT_W'(NCYC - 1));
`ifdef ADDSUB_EQ_EARLY_EXIT_EN
    early_hit  = is_eq_op(op_q) && (|sum_k);
`else
    early_hit  = 1'b0;
`endif
    finish     = last_chunk || early_hit;
    v_flag     = cmsb_k ^ cout_k;
    lt_flag    = sum_k[WADD-1] ^ v_flag;
    ltu_flag   = ~cout_k;
    full_sum   = WIDTH'({sum_k, res_q} >> WADD);
    cond_nxt   = 1'b0;
    case (op_q)
      EQ:      cond_nxt = ~nz_next;
      NE:      cond_nxt = nz_next;
      LT:      cond_nxt = lt_flag;
      GE:      cond_nxt = ~lt_flag;
      LTU:     cond_nxt = ltu_flag;
      GEU:     cond_nxt = ~ltu_flag;
      default: cond_nxt = 1'b0;
    endcase
    ovf_nxt = ((op_q == ADD) || (op_q == SUB)) ? v_flag : 1'b0;
  end

  // Handshake outputs and next-state selection.
  always_comb begin
    in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
    out_valid = (state == DONE);
    accept    = in_valid && in_ready;
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = RUN;
      RUN:     if (finish) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = in_valid ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Operand capture, per-chunk accumulation and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q   <= ADD;
      a_sh   <= '0;
      b_sh   <= '0;
      res_q  <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      nz     <= 1'b0;
      out_q  <= '0;
      cond_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (accept) begin
      op_q  <= op;
      a_sh  <= src_a;
      b_sh  <= src_b;
      cnt   <= '0;
      carry <= (op != ADD);
      nz    <= 1'b0;
    end else if (state == RUN) begin
      a_sh  <= a_sh >> WADD;
      b_sh  <= b_sh >> WADD;
      res_q <= full_sum;
      carry <= cout_k;
      nz    <= nz_next;
      cnt   <= cnt + 1'b1;
      if (finish) begin
        out_q  <= ((op_q == ADD) || (op_q == SUB)) ? full_sum : WIDTH'(cond_nxt);
        cond_q <= cond_nxt;
        ovf_q  <= ovf_nxt;
      end
    end
  end

  assign out       = out_q;
  assign cond      = cond_q;
  assign ovf       = ovf_q;
  assign state_dbg = state;

endmodule
